// File: rtl/apple1_pkg.sv
// Shared constants and types for the Apple-I text capture path.
package apple1_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [6:0] PRINT_LO = 7'h20;
  localparam logic [6:0] PRINT_HI = 7'h5F;

  typedef enum logic {
    CAPTURE = 1'b0,
    UPLOAD  = 1'b1
  } cap_state_t;

  // Characters worth keeping in a transcript: CR plus the Apple-I printable range.
  function automatic logic char_accept(input logic [6:0] c);
    return (c == ASCII_CR[6:0]) || ((c >= PRINT_LO) && (c <= PRINT_HI));
  endfunction

endpackage

// File: rtl/text_capture_if.sv
// Display-snoop and hps_io upload signals of the text capture block.
interface text_capture_if #(
  parameter int unsigned ADDR_W = 13
);

  logic              char_we;
  logic [6:0]        char_data;
  logic              clear;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W:0]   used;
  logic              overflow;

  modport master (
    output char_we, char_data, clear, ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, used, overflow
  );

  modport slave (
    input  char_we, char_data, clear, ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, used, overflow
  );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port byte RAM: port A writes, port B reads with one registered cycle.
module capture_ram #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_sys,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_capture.sv
// Captures characters written to the Apple-I display into a buffer and
// serves that buffer to the HPS over the ioctl upload channel.
module text_capture
  import apple1_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter bit          WRAP     = 1'b0,
  parameter bit          CR_TO_LF = 1'b1
) (
  input  logic           clk_sys,
  input  logic           reset,
  text_capture_if.slave  bus
);

  localparam int unsigned   DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] USED_FULL = (ADDR_W+1)'(DEPTH);

  cap_state_t        state_q, state_d;
  logic              upload_q;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   used_q, used_d;
  logic              ovf_q, ovf_d;
  logic              pend_q;
  logic              oob_q;
  logic [7:0]        din_q;

  logic              char_ok;
  logic              full;
  logic              ram_we;
  logic              rd_go;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        ram_rdata;

  assign char_ok = bus.char_we && char_accept(bus.char_data);
  assign full    = (used_q == USED_FULL);
  assign wdata   = (CR_TO_LF && (bus.char_data == ASCII_CR[6:0])) ? ASCII_LF
                                                                  : {1'b0, bus.char_data};
  // Logical upload address is relative to the oldest byte still held.
  assign raddr   = base_q + bus.ioctl_addr;

  always_comb begin
    state_d = state_q;
    ram_we  = 1'b0;
    rd_go   = 1'b0;
    wptr_d  = wptr_q;
    base_d  = base_q;
    used_d  = used_q;
    ovf_d   = ovf_q;
    case (state_q)
      CAPTURE: begin
        if (bus.ioctl_upload && !upload_q) state_d = UPLOAD;
        if (char_ok) begin
          if (!full) begin
            ram_we = 1'b1;
            wptr_d = wptr_q + ADDR_W'(1);
            used_d = used_q + (ADDR_W+1)'(1);
          end else if (WRAP) begin
            ram_we = 1'b1;
            wptr_d = wptr_q + ADDR_W'(1);
            base_d = base_q + ADDR_W'(1);
            ovf_d  = 1'b1;
          end else begin
            ovf_d  = 1'b1;
          end
        end
      end
      UPLOAD: begin
        if (!bus.ioctl_upload && upload_q) state_d = CAPTURE;
        if (char_ok) ovf_d = 1'b1;
        rd_go = bus.ioctl_rd && !pend_q;
      end
      default: state_d = CAPTURE;
    endcase
    // Clear overrides everything, including a coincident character.
    if (bus.clear) begin
      ram_we = 1'b0;
      wptr_d = '0;
      base_d = '0;
      used_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= CAPTURE;
      upload_q <= 1'b0;
      wptr_q   <= '0;
      base_q   <= '0;
      used_q   <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      oob_q    <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      upload_q <= bus.ioctl_upload;
      wptr_q   <= wptr_d;
      base_q   <= base_d;
      used_q   <= used_d;
      ovf_q    <= ovf_d;
      pend_q   <= rd_go;
      if (rd_go)  oob_q <= ({1'b0, bus.ioctl_addr} >= used_q);
      if (pend_q) din_q <= oob_q ? 8'h00 : ram_rdata;
    end
  end

  capture_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_sys (clk_sys),
    .we      (ram_we),
    .waddr   (wptr_q),
    .wdata   (wdata),
    .re      (rd_go),
    .raddr   (raddr),
    .rdata   (ram_rdata)
  );

  // Stall covers the request cycle and the RAM cycle; reset drops it at once.
  assign bus.ioctl_wait = !reset && (rd_go || pend_q);
  assign bus.ioctl_din  = din_q;
  assign bus.used       = used_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_text_capture.sv
// Scoreboard bench for text_capture: a stop-when-full and a ring instance share stimulus.
module tb_text_capture;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  text_capture_if #(.ADDR_W(AW)) bus0 ();
  text_capture_if #(.ADDR_W(AW)) bus1 ();

  assign bus1.char_we      = bus0.char_we;
  assign bus1.char_data    = bus0.char_data;
  assign bus1.clear        = bus0.clear;
  assign bus1.ioctl_upload = bus0.ioctl_upload;
  assign bus1.ioctl_rd     = bus0.ioctl_rd;
  assign bus1.ioctl_addr   = bus0.ioctl_addr;

  text_capture #(.ADDR_W(AW), .WRAP(1'b0), .CR_TO_LF(1'b1)) dut0 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus0.slave)
  );

  text_capture #(.ADDR_W(AW), .WRAP(1'b1), .CR_TO_LF(1'b1)) dut1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: buffer contents as a queue of bytes, oldest first.
  logic [7:0] mq    [2][$];
  bit         movf  [2];
  bit         m_upload;
  logic [7:0] exp_q [2][$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_accept(input logic [6:0] c);
    return (c == 7'h0D) || (c >= 7'h20 && c <= 7'h5F);
  endfunction

  task automatic model_char(input logic [6:0] c);
    logic [7:0] b;
    b = (c == 7'h0D) ? 8'h0A : {1'b0, c};
    if (!m_accept(c)) return;
    for (int m = 0; m < 2; m++) begin
      if (m_upload) movf[m] = 1'b1;
      else if (mq[m].size() < DEPTH) mq[m].push_back(b);
      else if (m == 1) begin
        void'(mq[m].pop_front());
        mq[m].push_back(b);
        movf[m] = 1'b1;
      end else movf[m] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      movf[m] = 1'b0;
    end
  endtask

  task automatic send_char(input logic [6:0] c);
    @(posedge clk_sys); #1;
    bus0.char_we   = 1'b1;
    bus0.char_data = c;
    model_char(c);
    @(posedge clk_sys); #1;
    bus0.char_we   = 1'b0;
  endtask

  task automatic do_clear(input bit with_char, input logic [6:0] c);
    @(posedge clk_sys); #1;
    bus0.clear     = 1'b1;
    bus0.char_we   = with_char;
    bus0.char_data = c;
    model_clear();
    @(posedge clk_sys); #1;
    bus0.clear     = 1'b0;
    bus0.char_we   = 1'b0;
  endtask

  task automatic set_upload(input bit v);
    @(posedge clk_sys); #1;
    bus0.ioctl_upload = v;
    m_upload = v;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_read(input int a, input bit hold);
    @(posedge clk_sys); #1;
    bus0.ioctl_rd   = 1'b1;
    bus0.ioctl_addr = AW'(a);
    for (int m = 0; m < 2; m++)
      exp_q[m].push_back((a < mq[m].size()) ? mq[m][a] : 8'h00);
    // A held request must not start a second read while one is pending.
    if (hold) @(posedge clk_sys);
    @(posedge clk_sys); #1;
    bus0.ioctl_rd = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_status(input string tag);
    check($sformatf("%s_used0", tag), int'(bus0.used), mq[0].size());
    check($sformatf("%s_ovf0", tag),  int'(bus0.overflow), int'(movf[0]));
    check($sformatf("%s_used1", tag), int'(bus1.used), mq[1].size());
    check($sformatf("%s_ovf1", tag),  int'(bus1.overflow), int'(movf[1]));
  endtask

  // Monitor: a completed read is signalled by ioctl_wait falling.
  logic       mw     [2];
  logic [7:0] md     [2];
  bit         prev_w [2];
  int         wcnt   [2];
  logic [7:0] exp_b;

  always @(negedge clk_sys) begin
    mw[0] = bus0.ioctl_wait;
    mw[1] = bus1.ioctl_wait;
    md[0] = bus0.ioctl_din;
    md[1] = bus1.ioctl_din;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        prev_w[m] = 1'b0;
        wcnt[m]   = 0;
      end else begin
        if (mw[m]) wcnt[m]++;
        else if (prev_w[m]) begin
          if (exp_q[m].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read dut%0d: got din 0x%0h expected no read", m, md[m]);
          end else begin
            exp_b = exp_q[m].pop_front();
            check($sformatf("din_dut%0d", m), int'(md[m]), int'(exp_b));
            check($sformatf("wait_cycles_dut%0d", m), wcnt[m], 2);
          end
          wcnt[m] = 0;
        end
        prev_w[m] = mw[m];
      end
    end
  end

  string hello = "HELLO";

  initial begin
    bus0.char_we      = 1'b0;
    bus0.char_data    = 7'h00;
    bus0.clear        = 1'b0;
    bus0.ioctl_upload = 1'b0;
    bus0.ioctl_rd     = 1'b0;
    bus0.ioctl_addr   = '0;
    m_upload          = 1'b0;
    model_clear();
    reset = 1'b1;
    #1;
    check("reset_din",  int'(bus0.ioctl_din), 0);
    check("reset_wait", int'(bus0.ioctl_wait), 0);
    check_status("reset");
    @(posedge clk_sys); #1;
    reset = 1'b0;

    // Filtered codes leave the buffer untouched
    send_char(7'h07);
    send_char(7'h7F);
    send_char(7'h60);
    check_status("filtered");
    send_char(7'h41);
    check_status("accept_A");
    set_upload(1'b1);
    do_read(0, 1'b0);
    set_upload(1'b0);

    // HELLO + CR, read back including one address past the end
    do_clear(1'b0, 7'h00);
    for (int i = 0; i < hello.len(); i++) send_char(7'(hello[i]));
    send_char(7'h0D);
    set_upload(1'b1);
    check_status("hello");
    for (int a = 0; a < 7; a++) do_read(a, 1'b0);

    // Freeze during upload, accepted again afterwards
    send_char(7'h5A);
    check_status("freeze");
    set_upload(1'b0);
    send_char(7'h5A);
    check_status("after_freeze");

    // Fill / ring: 'A'..'T'
    do_clear(1'b0, 7'h00);
    for (int i = 0; i < 20; i++) send_char(7'(7'h41 + i));
    check_status("fill");
    set_upload(1'b1);
    do_read(0, 1'b0);
    do_read(15, 1'b0);
    do_read(7, 1'b1);
    set_upload(1'b0);

    // Randomized sessions
    for (int r = 0; r < 8; r++) begin
      int n;
      if ($urandom_range(0, 2) == 0) do_clear(1'b0, 7'h00);
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) send_char(7'($urandom_range(0, 127)));
        else send_char(7'($urandom_range(32'h20, 32'h5F)));
      end
      check_status($sformatf("rand%0d_cap", r));
      set_upload(1'b1);
      for (int k = 0; k < 6; k++) begin
        do_read($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) send_char(7'($urandom_range(32'h20, 32'h5F)));
      end
      check_status($sformatf("rand%0d_up", r));
      set_upload(1'b0);
    end

    // Clear coincident with a character after an overflow
    do_clear(1'b0, 7'h00);
    for (int i = 0; i < 17; i++) send_char(7'h42);
    check_status("pre_collide");
    do_clear(1'b1, 7'h51);
    check_status("collide");

    // Clear during upload: reads return zero
    send_char(7'h43);
    set_upload(1'b1);
    do_read(0, 1'b0);
    do_clear(1'b0, 7'h00);
    do_read(0, 1'b0);
    send_char(7'h44);
    check_status("clear_upload");

    // Reset while a read is pending
    set_upload(1'b0);
    send_char(7'h4B);
    set_upload(1'b1);
    do_read(0, 1'b0);
    @(posedge clk_sys); #1;
    bus0.ioctl_rd   = 1'b1;
    bus0.ioctl_addr = AW'(0);
    @(posedge clk_sys); #1;
    bus0.ioctl_rd = 1'b0;
    check("pending_wait", int'(bus0.ioctl_wait), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_wait0", int'(bus0.ioctl_wait), 0);
    check("rst_din0",  int'(bus0.ioctl_din), 0);
    check("rst_wait1", int'(bus1.ioctl_wait), 0);
    check("rst_din1",  int'(bus1.ioctl_din), 0);
    bus0.ioctl_upload = 1'b0;
    m_upload = 1'b0;
    model_clear();
    @(posedge clk_sys); #1;
    reset = 1'b0;
    check_status("post_reset");

    repeat (4) @(posedge clk_sys);
    #1;
    check("leftover_reads0", exp_q[0].size(), 0);
    check("leftover_reads1", exp_q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_capture.md
Name: text_capture

Overview:
- Reader-side counterpart of the ASCII text-load path.
- Snoops characters the Apple-I sends to its terminal (display PIA writes) and stores them in an on-chip buffer.
- Serves the buffer to the HPS through the hps_io ioctl upload channel, so a session transcript can be saved as a .TXT file.
- Sits in the emu top level between the apple1 core's display-write strobe and hps_io.

Parameters:
- ADDR_W, 13: buffer address width; depth = 2**ADDR_W bytes (8192).
- WRAP, 0: 0 = stop capturing when full; 1 = overwrite oldest byte (ring).
- CR_TO_LF, 1: 1 = store Apple-I CR (0x0D) as LF (0x0A); 0 = store CR unchanged.

Ports:
- clk_sys  in  1  system clock (25 MHz domain of apple1).
- reset  in  1  asynchronous, active-high reset.
- char_we  in  1  one-cycle strobe: apple1 is writing a character to the display.
- char_data  in  7  ASCII code accompanying char_we.
- clear  in  1  one-cycle pulse: empty the buffer and clear flags.
- ioctl_upload  in  1  hps_io upload active.
- ioctl_rd  in  1  hps_io read request, one cycle.
- ioctl_addr  in  ADDR_W  byte address being read.
- ioctl_din  out  8  read data to hps_io.
- ioctl_wait  out  1  stall to hps_io while read data is pending.
- used  out  ADDR_W+1  number of valid bytes in the buffer.
- overflow  out  1  sticky: at least one character was lost.

Behaviour:
- Reset values (asynchronous): ioctl_din=0x00, ioctl_wait=0, used=0, overflow=0; write pointer=0, base pointer=0; state=CAPTURE. Buffer RAM contents are not reset.
- Character filter, applied on char_we:
  - 0x0D is accepted; it is stored as 0x0A if CR_TO_LF=1, else as 0x0D.
  - 0x20..0x5F is accepted and stored as {1'b0,char_data}.
  - All other codes are ignored; no flag change.
- State machine:
  - CAPTURE -> UPLOAD when ioctl_upload rises.
  - UPLOAD -> CAPTURE when ioctl_upload falls.
  - reset forces CAPTURE.
- CAPTURE, accepted character:
  - Written to RAM[wptr] in the same cycle; wptr increments (mod depth).
  - used increments, saturating at depth.
- CAPTURE, buffer full (used == depth):
  - WRAP=0: character dropped, overflow set.
  - WRAP=1: character written; base advances by 1 (mod depth); used stays at depth; overflow set.
- UPLOAD:
  - Buffer frozen: accepted characters are dropped and overflow is set.
  - Read on ioctl_rd:
    - cycle 0: ioctl_wait asserted combinationally with ioctl_rd and held.
    - RAM read of physical address (base + ioctl_addr) mod depth, sampled at the ioctl_rd cycle.
    - synchronous RAM, 1-cycle latency.
    - cycle 2: ioctl_din registered; ioctl_wait deasserts.
    - Total: 2-cycle read latency; ioctl_din holds its value until the next read.
    - If ioctl_addr >= used, ioctl_din = 0x00, with the same timing.
    - ioctl_rd while a read is already pending is ignored.
- clear:
  - used=0, wptr=0, base=0, overflow=0, in any state.
  - clear and char_we in the same cycle: clear wins, character discarded.
  - clear during UPLOAD: subsequent reads return 0x00.
- Arithmetic: pointers are ADDR_W bits and wrap naturally; used is ADDR_W+1 bits so it can represent depth.
- Reset mid-read: ioctl_wait drops immediately (asynchronous), pending read abandoned.

Decomposition:
- Shared package apple1_pkg:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A, PRINT_LO=7'h20, PRINT_HI=7'h5F.
  - Enum typedef cap_state_t {CAPTURE, UPLOAD}.
- One sub-module: capture_ram, a simple dual-port synchronous RAM.
  - Port A: write. Port B: registered read.
  - ADDR_W parameter, 8-bit data; infers M10K.
- Control, filter and pointers stay in text_capture.

Test Plan:
- Reset, then char_we with "HELLO" then 0x0D (CR_TO_LF=1); raise ioctl_upload; read addr 0..6 -> bytes 48 45 4C 4C 4F 0A 00; used=6; each read has ioctl_wait high exactly 2 cycles.
- Filtered codes: char_we with 0x07, 0x7F, 0x60 -> used stays 0, overflow stays 0; then 0x41 -> used=1, RAM[0]=0x41.
- Fill (ADDR_W=4 bench, WRAP=0): 17 accepted chars 'A'..'Q' -> used=16, overflow=1, upload addr 15 returns 'P'.
- Ring mode (ADDR_W=4, WRAP=1): 20 chars 'A'..'T' -> used=16, overflow=1; upload addr 0 -> 'E', addr 15 -> 'T'.
- Freeze: char 'Z' during upload -> dropped, overflow=1, used unchanged; after ioctl_upload falls, 'Z' is accepted and used increments.
- Collisions and async reset:
  - clear coincident with char_we -> used=0, overflow=0, character lost.
  - reset asserted while ioctl_wait=1 -> ioctl_wait=0 and ioctl_din=0x00 immediately.
